// File: rtl/antilog_accum_seq_if.sv
// Packet-in / result-out handshake bundle for antilog_accum_seq.
// The slave modport is the accumulator's view; the master modport is the producer/consumer side.
interface antilog_accum_seq_if #(
  parameter int Q_ORD     = 7,
  parameter int WIDTH     = 16,
  parameter int LOG_WIDTH = 17
);
  logic                       in_valid;
  logic                       in_ready;
  logic [Q_ORD*LOG_WIDTH-1:0] log_in_packed;
  logic [Q_ORD-1:0]           sign_in_packed;
  logic [Q_ORD-1:0]           valid_in_packed;
  logic [WIDTH-1:0]           y_out;
  logic                       out_valid;
  logic                       out_ready;

  modport master (
    output in_valid, log_in_packed, sign_in_packed, valid_in_packed, out_ready,
    input  in_ready, y_out, out_valid
  );

  modport slave (
    input  in_valid, log_in_packed, sign_in_packed, valid_in_packed, out_ready,
    output in_ready, y_out, out_valid
  );
endinterface

// File: rtl/antilog_accum_seq.sv
// Sequential Mitchell antilog accumulator: converts Q_ORD log-domain terms, one per cycle,
// and sums them into a signed linear result. Define ANTILOG_SAT_EN to saturate the output.
module antilog_accum_seq #(
  parameter int Q_ORD     = 7,
  parameter int WIDTH     = 16,
  parameter int QP        = 12,
  parameter int LOG_WIDTH = 17,
  parameter int ACC_WIDTH = WIDTH + 4
) (
  input  logic                clk,
  input  logic                reset,
  antilog_accum_seq_if.slave  bus
);

  localparam int LF = LOG_WIDTH - 5;
  localparam int IW = $clog2(Q_ORD + 1);
  localparam logic [63:0] MAG_MAX = (64'd1 << (WIDTH - 1)) - 64'd1;
  localparam logic signed [ACC_WIDTH-1:0] SMAX = ACC_WIDTH'(MAG_MAX);
  localparam logic signed [ACC_WIDTH-1:0] SMIN = -SMAX - ACC_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_e;

  state_e                        state_q, state_d;
  logic [IW-1:0]                 idx_q, idx_d;
  logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [Q_ORD*LOG_WIDTH-1:0]    log_q, log_d;
  logic [Q_ORD-1:0]              sign_q, sign_d;
  logic [Q_ORD-1:0]              vld_q, vld_d;
  logic [WIDTH-1:0]              y_q, y_d;

  logic [IW-1:0]                 idx_sel;
  logic [LOG_WIDTH-1:0]          term_log;
  logic signed [4:0]             term_exp;
  logic [LF:0]                   mant;
  int                            sh;
  logic [63:0]                   mag_w;
  logic [ACC_WIDTH-1:0]          mag;
  logic signed [ACC_WIDTH-1:0]   term;
  logic [WIDTH-1:0]              res;

  // idx_q reaches Q_ORD on the finishing cycle; keep the part-select in range.
  assign idx_sel  = (idx_q < IW'(Q_ORD)) ? idx_q : '0;
  assign term_log = log_q[int'(idx_sel)*LOG_WIDTH +: LOG_WIDTH];
  assign term_exp = $signed(term_log[LOG_WIDTH-1:LF]);
  assign mant     = {1'b1, term_log[LF-1:0]};

  always_comb begin
    sh    = int'(term_exp) + QP - LF;
    mag_w = 64'(mant);
    if (sh >= 63 - LF)      mag_w = MAG_MAX + 64'd1;
    else if (sh >= 0)       mag_w = mag_w << sh;
    else if (sh <= -64)     mag_w = '0;
    else                    mag_w = mag_w >> (-sh);
    mag  = (mag_w > MAG_MAX) ? ACC_WIDTH'(MAG_MAX) : ACC_WIDTH'(mag_w);
    term = '0;
    if (vld_q[idx_sel]) term = sign_q[idx_sel] ? -$signed(mag) : $signed(mag);
  end

`ifdef ANTILOG_SAT_EN
  always_comb begin
    if (acc_q > SMAX)      res = SMAX[WIDTH-1:0];
    else if (acc_q < SMIN) res = SMIN[WIDTH-1:0];
    else                   res = acc_q[WIDTH-1:0];
  end
`else
  always_comb res = acc_q[WIDTH-1:0];
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    log_d   = log_q;
    sign_d  = sign_q;
    vld_d   = vld_q;
    y_d     = y_q;
    case (state_q)
      IDLE: if (bus.in_valid) begin
        log_d   = bus.log_in_packed;
        sign_d  = bus.sign_in_packed;
        vld_d   = bus.valid_in_packed;
        acc_d   = '0;
        idx_d   = '0;
        state_d = CONV;
      end
      CONV: begin
        // One extra cycle after the last term publishes the result.
        if (idx_q == IW'(Q_ORD)) begin
          y_d     = res;
          state_d = DONE;
        end else begin
          acc_d = acc_q + term;
          idx_d = idx_q + IW'(1);
        end
      end
      DONE: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      log_q   <= '0;
      sign_q  <= '0;
      vld_q   <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      log_q   <= log_d;
      sign_q  <= sign_d;
      vld_q   <= vld_d;
      y_q     <= y_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.y_out     = y_q;

endmodule
